// File: rtl/lpc_pkg.sv
// ----------------------------------------------------------------------------
// Module   : lpc_pkg
// Brief    : Shared constants, state encoding and order check for the LPC
//            coefficient server.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package lpc_pkg;

  localparam int COEFF_WIDTH = 12;
  localparam int MAX_ORDER   = 12;
  localparam int ORDER_WIDTH = 4;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;
  localparam logic [1:0] ST_SERVING = 2'd3;

  function automatic logic order_valid(input int unsigned order, input int unsigned max_order);
    return (order >= 1) && (order <= max_order);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lpc_coeff_regfile.sv
// ----------------------------------------------------------------------------
// Module   : lpc_coeff_regfile
// Brief    : Coefficient storage, one synchronous write port and one
//            registered read port.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lpc_coeff_regfile #(
  parameter int COEFF_WIDTH = 12,
  parameter int MAX_ORDER   = 12,
  parameter int ORDER_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_we,
  input  logic [ORDER_WIDTH-1:0] i_waddr,
  input  logic [COEFF_WIDTH-1:0] i_wdata,
  input  logic                   i_re,
  input  logic [ORDER_WIDTH-1:0] i_raddr,
  output logic [COEFF_WIDTH-1:0] o_rdata
);

  logic [COEFF_WIDTH-1:0] r_mem [MAX_ORDER];
  logic [COEFF_WIDTH-1:0] r_rdata;

  // Storage carries no reset; only the read register is cleared.
  always_ff @(posedge i_clk) begin
    if (i_en && i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rdata <= '0;
    end else if (i_en && i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/lpc_coefficient_server.sv
// ----------------------------------------------------------------------------
// Module   : lpc_coefficient_server
// Brief    : Holds one quantised LPC coefficient set and replays it to the
//            predictor MAC, highest tap first, once per decoded sample.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lpc_coefficient_server #(
  parameter int COEFF_WIDTH = lpc_pkg::COEFF_WIDTH,
  parameter int MAX_ORDER   = lpc_pkg::MAX_ORDER,
  parameter int ORDER_WIDTH = lpc_pkg::ORDER_WIDTH
) (
  input  logic                   iClock,
  input  logic                   iReset,
  input  logic                   iEnable,
  input  logic                   iClear,
  input  logic                   iLoad,
  input  logic [ORDER_WIDTH-1:0] iOrder,
  input  logic [COEFF_WIDTH-1:0] iCoeff,
  input  logic                   iStart,
  output logic [COEFF_WIDTH-1:0] oCoeff,
  output logic [ORDER_WIDTH-1:0] oIndex,
  output logic                   oValid,
  output logic                   oLast,
  output logic                   oLoaded,
  output logic                   oError
);

  import lpc_pkg::*;

  localparam logic [ORDER_WIDTH-1:0] C_ONE = ORDER_WIDTH'(1);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nxt;
  logic [ORDER_WIDTH-1:0] r_order;
  logic [ORDER_WIDTH-1:0] r_count;
  logic [ORDER_WIDTH-1:0] r_index;
  logic                   r_valid;
  logic                   r_last;
  logic                   r_loaded;
  logic                   r_error;

  logic                   w_order_ok;
  logic                   w_we;
  logic [ORDER_WIDTH-1:0] w_waddr;
  logic                   w_issue;
  logic [ORDER_WIDTH-1:0] w_issue_idx;
  logic                   w_err_set;

  assign w_order_ok = order_valid(32'(iOrder), MAX_ORDER);

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_state  <= ST_EMPTY;
      r_order  <= '0;
      r_count  <= '0;
      r_index  <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_loaded <= 1'b0;
      r_error  <= 1'b0;
    end else if (iEnable) begin
      r_state  <= w_state_nxt;
      r_loaded <= (w_state_nxt == ST_READY) || (w_state_nxt == ST_SERVING);
      if (iClear) begin
        r_count <= '0;
        r_error <= 1'b0;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else begin
        if (w_err_set) begin
          r_error <= 1'b1;
        end
        if (w_we) begin
          r_count <= w_waddr + C_ONE;
          if (r_state != ST_LOADING) begin
            r_order <= iOrder;
          end
        end
        r_valid <= w_issue;
        r_last  <= w_issue && (w_issue_idx == '0);
        if (w_issue) begin
          r_index <= w_issue_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY, ST_READY: begin
        if (iLoad) begin
          if (w_order_ok) begin
            w_state_nxt = (iOrder == C_ONE) ? ST_READY : ST_LOADING;
          end
        end else if (iStart && (r_state == ST_READY)) begin
          w_state_nxt = ST_SERVING;
        end
      end
      ST_LOADING: begin
        if (iLoad && ((r_count + C_ONE) == r_order)) begin
          w_state_nxt = ST_READY;
        end
      end
      default: begin
        // A start on the final tap chains straight into the next pass.
        if ((r_index == '0) && !iStart) begin
          w_state_nxt = ST_READY;
        end
      end
    endcase
    if (iClear) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = r_count;
    w_issue     = 1'b0;
    w_issue_idx = r_index - C_ONE;
    w_err_set   = 1'b0;
    case (r_state)
      ST_EMPTY, ST_READY: begin
        if (iLoad) begin
          w_we      = w_order_ok;
          w_waddr   = '0;
          w_err_set = !w_order_ok || iStart;
        end else if (iStart) begin
          if (r_state == ST_READY) begin
            w_issue     = 1'b1;
            w_issue_idx = r_order - C_ONE;
          end else begin
            w_err_set = 1'b1;
          end
        end
      end
      ST_LOADING: begin
        w_we      = iLoad;
        w_err_set = iStart;
      end
      default: begin
        w_err_set = iLoad;
        if (r_index == '0) begin
          w_issue     = iStart;
          w_issue_idx = r_order - C_ONE;
        end else begin
          w_issue   = 1'b1;
          w_err_set = iLoad || iStart;
        end
      end
    endcase
    if (iClear) begin
      w_we      = 1'b0;
      w_issue   = 1'b0;
      w_err_set = 1'b0;
    end
  end

  lpc_coeff_regfile #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .MAX_ORDER   (MAX_ORDER),
    .ORDER_WIDTH (ORDER_WIDTH)
  ) u_regfile (
    .i_clk   (iClock),
    .i_rst_n (iReset),
    .i_en    (iEnable),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (iCoeff),
    .i_re    (w_issue),
    .i_raddr (w_issue_idx),
    .o_rdata (oCoeff)
  );

  assign oIndex  = r_index;
  assign oValid  = r_valid;
  assign oLast   = r_last;
  assign oLoaded = r_loaded;
  assign oError  = r_error;

endmodule

`default_nettype wire

// File: tb/tb_lpc_coefficient_server.sv
// ----------------------------------------------------------------------------
// Module   : tb_lpc_coefficient_server
// Brief    : Self-checking bench for lpc_coefficient_server.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lpc_coefficient_server;

  localparam int CW = 12;
  localparam int MO = 12;
  localparam int OW = 4;

  logic          iClock = 1'b0;
  logic          iReset, iEnable, iClear, iLoad, iStart;
  logic [OW-1:0] iOrder;
  logic [CW-1:0] iCoeff;
  logic [CW-1:0] oCoeff;
  logic [OW-1:0] oIndex;
  logic          oValid, oLast, oLoaded, oError;

  int checks = 0;
  int errors = 0;

  // Reference model: the held set, its order, and the sticky error flag.
  logic [CW-1:0] m_q     [MO];
  logic [CW-1:0] m_stage [MO];
  int            m_order;
  logic          m_err;

  always #5 iClock = ~iClock;

  lpc_coefficient_server dut (
    .iClock  (iClock),
    .iReset  (iReset),
    .iEnable (iEnable),
    .iClear  (iClear),
    .iLoad   (iLoad),
    .iOrder  (iOrder),
    .iCoeff  (iCoeff),
    .iStart  (iStart),
    .oCoeff  (oCoeff),
    .oIndex  (oIndex),
    .oValid  (oValid),
    .oLast   (oLast),
    .oLoaded (oLoaded),
    .oError  (oError)
  );

  task automatic step();
    @(negedge iClock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_set(input int order);
    for (int i = 0; i < order; i++) begin
      iLoad  = 1'b1;
      iOrder = OW'(order);
      iCoeff = m_stage[i];
      step();
      if (i == 0 && order > 1) chk("loaded_mid", 32'(oLoaded), 0);
    end
    iLoad = 1'b0;
    for (int i = 0; i < order; i++) m_q[i] = m_stage[i];
    m_order = order;
    chk("loaded_done", 32'(oLoaded), 1);
  endtask

  task automatic stage_random(input int order);
    for (int i = 0; i < order; i++) m_stage[i] = CW'($urandom);
  endtask

  // Runs n back-to-back passes; inject >= 0 raises iLoad+iStart at that tap.
  task automatic run_passes(input int n, input int inject);
    int idx;
    iStart = 1'b1;
    step();
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < m_order; k++) begin
        idx = m_order - 1 - k;
        chk("valid", 32'(oValid), 1);
        chk("index", 32'(oIndex), 32'(idx));
        chk("coeff", 32'(oCoeff), 32'(m_q[idx]));
        chk("last", 32'(oLast), 32'(k == m_order - 1));
        iStart = (k == m_order - 1) && (p < n - 1);
        iLoad  = 1'b0;
        if (k == inject && k != m_order - 1) begin
          iStart = 1'b1;
          iLoad  = 1'b1;
          iOrder = OW'($urandom_range(1, MO));
          iCoeff = CW'($urandom);
          m_err  = 1'b1;
        end
        step();
      end
    end
    iStart = 1'b0;
    iLoad  = 1'b0;
    chk("valid_drop", 32'(oValid), 0);
    chk("error", 32'(oError), 32'(m_err));
    chk("loaded_hold", 32'(oLoaded), 1);
  endtask

  task automatic clear();
    iClear = 1'b1;
    step();
    iClear = 1'b0;
    m_err  = 1'b0;
    chk("clear_error", 32'(oError), 0);
    chk("clear_loaded", 32'(oLoaded), 0);
  endtask

  initial begin
    iReset = 1'b0; iEnable = 1'b1; iClear = 1'b0; iLoad = 1'b0; iStart = 1'b0;
    iOrder = '0;   iCoeff = '0;    m_err = 1'b0;  m_order = 0;
    step(); step();
    chk("rst_coeff", 32'(oCoeff), 0);
    chk("rst_index", 32'(oIndex), 0);
    chk("rst_valid", 32'(oValid), 0);
    chk("rst_last", 32'(oLast), 0);
    chk("rst_loaded", 32'(oLoaded), 0);
    chk("rst_error", 32'(oError), 0);
    iReset = 1'b1;
    step();

    // Directed order-4 set.
    m_stage[0] = CW'(5); m_stage[1] = CW'(-3); m_stage[2] = CW'(100); m_stage[3] = CW'(-2048);
    load_set(4);
    run_passes(1, -1);

    // Order 12, three chained passes.
    stage_random(12);
    load_set(12);
    run_passes(3, -1);

    // Illegal orders in EMPTY.
    clear();
    iLoad = 1'b1; iOrder = OW'(13); iCoeff = CW'($urandom);
    step();
    iLoad = 1'b0;
    chk("ord13_error", 32'(oError), 1);
    chk("ord13_loaded", 32'(oLoaded), 0);
    clear();
    iLoad = 1'b1; iOrder = '0; iCoeff = CW'($urandom);
    step();
    iLoad = 1'b0;
    chk("ord0_error", 32'(oError), 1);
    chk("ord0_loaded", 32'(oLoaded), 0);
    chk("ord0_valid", 32'(oValid), 0);
    clear();

    // Order 3 with load+start injected two taps into the pass.
    stage_random(3);
    load_set(3);
    run_passes(1, 1);
    run_passes(1, -1);
    clear();

    // Order 1 holding -1.
    m_stage[0] = CW'(-1);
    load_set(1);
    run_passes(1, -1);

    // Randomised sets loaded over READY.
    for (int r = 0; r < 6; r++) begin
      int ord;
      ord = $urandom_range(1, MO);
      stage_random(ord);
      load_set(ord);
      run_passes($urandom_range(1, 3), -1);
    end

    // Stall then reset mid-pass at tap index 3 of an order-6 set.
    stage_random(6);
    load_set(6);
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step(); step();
    chk("mid_index", 32'(oIndex), 3);
    iEnable = 1'b0;
    iStart  = 1'b1;
    step(); step();
    iStart  = 1'b0;
    chk("hold_valid", 32'(oValid), 1);
    chk("hold_index", 32'(oIndex), 3);
    chk("hold_coeff", 32'(oCoeff), 32'(m_q[3]));
    chk("hold_last", 32'(oLast), 0);
    iReset = 1'b0;
    step();
    m_err = 1'b0;
    chk("rst2_coeff", 32'(oCoeff), 0);
    chk("rst2_index", 32'(oIndex), 0);
    chk("rst2_valid", 32'(oValid), 0);
    chk("rst2_last", 32'(oLast), 0);
    chk("rst2_loaded", 32'(oLoaded), 0);
    chk("rst2_error", 32'(oError), 0);
    iReset  = 1'b1;
    iEnable = 1'b1;
    iStart  = 1'b1;
    step();
    iStart = 1'b0;
    chk("empty_start_error", 32'(oError), 1);
    chk("empty_start_valid", 32'(oValid), 0);
    chk("empty_start_loaded", 32'(oLoaded), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
